// File: rtl/pong_pkg.sv
// Shared types and screen constants for the pong game sequencer and its datapath.
// Latency: none; this file holds only types, constants and one helper function.
// Backpressure: none.
package pong_pkg;

    // Screen geometry (640x480 visible area).
    localparam int SCREEN_W     = 640;
    localparam int SCREEN_H     = 480;
    localparam int POS_W        = 10;

    // Default miss thresholds: the ball has passed a paddle face.
    localparam int MISS_L_X_DEF = 4;
    localparam int MISS_R_X_DEF = 635;

    // Paddle x positions used by the paddle/ball datapath.
    localparam int PADDLE_L_X   = 8;
    localparam int PADDLE_R_X   = 631;

    localparam int SCORE_W      = 4;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SERVE_WAIT = 3'd1,
        ST_PLAY       = 3'd2,
        ST_POINT      = 3'd3,
        ST_GAME_OVER  = 3'd4
    } game_state_t;

    // Score increment that never passes the winning score.
    function automatic logic [SCORE_W-1:0] score_sat_inc(
        input logic [SCORE_W-1:0] score,
        input logic [SCORE_W-1:0] limit
    );
        return (score < limit) ? score + SCORE_W'(1) : score;
    endfunction

endpackage

// File: rtl/pong_game_ctrl_tick_gen.sv
// Clock divider producing a one-cycle tick every DIV enabled cycles (motion or paddle rate).
// Latency: tick is combinational on the wrap cycle of the internal counter.
// Backpressure: en low freezes the counter in place; clr forces it to 0 and suppresses the tick.
//
// Ports: clk, rst_n (async active-low), en (count enable), clr (hold at 0), tick (wrap pulse).
module tick_gen #(
    parameter int DIV = 131072
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int              CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve timing, ball step enable, miss detection, scoring, game end.
// Latency: ball_step/ball_serve registered (1 cycle after tick); miss->score 1 cycle; score->next state 1 cycle.
// Backpressure: pause freezes the motion tick and all tick-driven counting; miss detection stays live.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   start, pause             debounced start level (rising edge used), pause level
//   ball_x_pos, ball_y_pos   ball position from the ball block (y only tapped, not used)
//   ball_step, ball_serve    one-cycle pulses to the ball block
//   serve_dir                1 = serve toward +x; updated at each point, held afterwards
//   left_score, right_score  player scores
//   game_over, winner        game finished, and who won (0 = left, 1 = right)
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int TICK_DIV    = 131072,
    parameter int SERVE_DELAY = 64,
    parameter int WIN_SCORE   = 9,
    parameter int MISS_L_X    = MISS_L_X_DEF,
    parameter int MISS_R_X    = MISS_R_X_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             pause,
    input  logic [9:0]       ball_x_pos,
    input  logic [9:0]       ball_y_pos,
    output logic             ball_step,
    output logic             ball_serve,
    output logic             serve_dir,
    output logic [3:0]       left_score,
    output logic [3:0]       right_score,
    output logic             game_over,
    output logic             winner
);

    localparam int                 DW       = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY + 1) : 1;
    localparam logic [DW-1:0]      DLY_LAST = DW'(SERVE_DELAY - 1);
    localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);
    localparam logic [POS_W-1:0]   MISS_L   = POS_W'(MISS_L_X);
    localparam logic [POS_W-1:0]   MISS_R   = POS_W'(MISS_R_X);

    game_state_t        state_q, state_d;
    logic [SCORE_W-1:0] left_score_q, left_score_d;
    logic [SCORE_W-1:0] right_score_q, right_score_d;
    logic               serve_dir_q, serve_dir_d;
    logic               winner_q, winner_d;
    logic               ball_step_q, ball_step_d;
    logic               ball_serve_q, ball_serve_d;
    logic [DW-1:0]      delay_cnt_q, delay_cnt_d;
    logic               start_q, start_d;

    logic tick;
    logic tick_clr;
    logic start_rise;

    // The y position is only carried for the score overlay tap.
    logic unused_y;
    assign unused_y = ^ball_y_pos;

    // Motion tick is parked at phase 0 while no game is in progress, so every
    // fresh game starts with a full, predictable serve delay.
    assign tick_clr   = (state_q == ST_IDLE) || (state_q == ST_GAME_OVER);
    assign start_rise = start && !start_q;

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_motion_tick (
        .clk   (clk),
        .rst_n (reset_n),
        .en    (!pause),
        .clr   (tick_clr),
        .tick  (tick)
    );

    always_comb begin
        state_d       = state_q;
        left_score_d  = left_score_q;
        right_score_d = right_score_q;
        serve_dir_d   = serve_dir_q;
        winner_d      = winner_q;
        delay_cnt_d   = delay_cnt_q;
        ball_step_d   = 1'b0;
        ball_serve_d  = 1'b0;
        start_d       = start;

        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    delay_cnt_d = '0;
                    state_d     = ST_SERVE_WAIT;
                end
            end

            ST_SERVE_WAIT: begin
                if (tick) begin
                    if (delay_cnt_q == DLY_LAST) begin
                        ball_serve_d = 1'b1;
                        delay_cnt_d  = '0;
                        state_d      = ST_PLAY;
                    end else begin
                        delay_cnt_d = delay_cnt_q + DW'(1);
                    end
                end
            end

            ST_PLAY: begin
                ball_step_d = tick;
                // Left miss wins a tie so the outcome is deterministic.
                if (ball_x_pos <= MISS_L) begin
                    right_score_d = score_sat_inc(right_score_q, WIN);
                    serve_dir_d   = 1'b0;
                    state_d       = ST_POINT;
                end else if (ball_x_pos >= MISS_R) begin
                    left_score_d = score_sat_inc(left_score_q, WIN);
                    serve_dir_d  = 1'b1;
                    state_d      = ST_POINT;
                end
            end

            ST_POINT: begin
                // serve_dir was just set toward the loser, so it also names the scorer:
                // 1 means the left player scored.
                if (serve_dir_q ? (left_score_q == WIN) : (right_score_q == WIN)) begin
                    winner_d = !serve_dir_q;
                    state_d  = ST_GAME_OVER;
                end else begin
                    delay_cnt_d = '0;
                    state_d     = ST_SERVE_WAIT;
                end
            end

            ST_GAME_OVER: begin
                if (start_rise) begin
                    left_score_d  = '0;
                    right_score_d = '0;
                    serve_dir_d   = 1'b1;
                    winner_d      = 1'b0;
                    delay_cnt_d   = '0;
                    state_d       = ST_SERVE_WAIT;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            left_score_q  <= '0;
            right_score_q <= '0;
            serve_dir_q   <= 1'b1;
            winner_q      <= 1'b0;
            ball_step_q   <= 1'b0;
            ball_serve_q  <= 1'b0;
            delay_cnt_q   <= '0;
            start_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            left_score_q  <= left_score_d;
            right_score_q <= right_score_d;
            serve_dir_q   <= serve_dir_d;
            winner_q      <= winner_d;
            ball_step_q   <= ball_step_d;
            ball_serve_q  <= ball_serve_d;
            delay_cnt_q   <= delay_cnt_d;
            start_q       <= start_d;
        end
    end

    assign ball_step   = ball_step_q;
    assign ball_serve  = ball_serve_q;
    assign serve_dir   = serve_dir_q;
    assign left_score  = left_score_q;
    assign right_score = right_score_q;
    assign game_over   = (state_q == ST_GAME_OVER);
    assign winner      = winner_q;

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game sequencer for the pong datapath. Generates the ball-motion step enable, serves the ball, detects misses at the left and right screen edges, keeps both scores, and ends the game at a winning score. Sits between the player inputs and the ball/paddle datapath; the ball block advances one pixel per `ball_step` and reloads its start position on `ball_serve`.

## Interface
- `TICK_DIV`, 131072: clk cycles per motion tick (2^17).
- `SERVE_DELAY`, 64: motion ticks between the end of a point and the next serve.
- `WIN_SCORE`, 9: score that ends the game (1..15).
- `MISS_L_X`, 4: ball_x_pos at or below this is a left miss.
- `MISS_R_X`, 635: ball_x_pos at or above this is a right miss.

- `clk`  in  1  system clock (25 MHz pixel clock).
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  synchronous level, already debounced; rising edge detected internally.
- `pause`  in  1  level; freezes the tick counter and all tick-driven counting.
- `ball_x_pos`  in  10  current ball x from the ball block.
- `ball_y_pos`  in  10  current ball y (unused for decisions, kept for the score overlay tap).
- `ball_step`  out  1  one-cycle pulse; ball moves one pixel.
- `ball_serve`  out  1  one-cycle pulse; ball reloads to centre.
- `serve_dir`  out  1  1 = serve toward +x, 0 = toward −x; valid with `ball_serve`, held afterwards.
- `left_score`  out  4  points won by the left player.
- `right_score`  out  4  points won by the right player.
- `game_over`  out  1  high in GAME_OVER.
- `winner`  out  1  0 = left, 1 = right; valid while `game_over`.

## Operation
- States: IDLE, SERVE_WAIT, PLAY, POINT, GAME_OVER.
- Reset: state IDLE, scores 0, `serve_dir` 1, `winner` 0, all pulses 0, tick counter 0, delay counter 0.
- IDLE: waits for a `start` rising edge → SERVE_WAIT.
- SERVE_WAIT: counts motion ticks; on tick number SERVE_DELAY, asserts `ball_serve` for one cycle → PLAY.
- PLAY: `ball_step` pulses on each motion tick. Each cycle: `ball_x_pos <= MISS_L_X` → right_score+1, `serve_dir` = 0; else `ball_x_pos >= MISS_R_X` → left_score+1, `serve_dir` = 1; either → POINT. Left miss has priority if both are true.
- POINT: one cycle. If the incremented score equals WIN_SCORE → GAME_OVER with `winner` set to the scorer; else → SERVE_WAIT with the delay counter cleared.
- GAME_OVER: scores held. A `start` rising edge clears both scores, sets `serve_dir` 1, → SERVE_WAIT.
- A `start` edge in SERVE_WAIT, PLAY or POINT is ignored.
- Scores saturate at WIN_SCORE; there is never an increment past it.
- `pause` high: the tick counter holds, with no `ball_step` and no SERVE_DELAY progress. Miss detection stays live, since the ball cannot move while paused.

## Timing
- Motion tick: the tick counter runs 0..TICK_DIV−1 and the tick fires on the wrap cycle. The counter runs in every state except IDLE and GAME_OVER, where it is held at 0.
- `ball_step` is registered: high in the cycle after the tick, only in PLAY.
- `ball_serve` is registered: high for exactly one cycle. PLAY is entered in that same cycle, and the first `ball_step` comes no earlier than the next tick.
- Serve latency from entering SERVE_WAIT: SERVE_DELAY × TICK_DIV cycles (± 1 tick of phase), excluding paused cycles.
- Miss to score update: 1 cycle (PLAY→POINT edge). Score to GAME_OVER or SERVE_WAIT: 1 further cycle.
- `start` edge detect: one register stage, so the response comes 1 cycle after the sampled rising edge.
- Reset asserted mid-game clears everything immediately (asynchronous), with no pulse emitted in that cycle.

## Structure
- Package `pong_pkg`: `game_state_t` enum, screen constants (640×480, MISS_L_X/MISS_R_X defaults, paddle x positions), score width constant.
- Sub-module `tick_gen`: parameterised divider with `en` input and a one-cycle `tick` output. It is reusable for the paddle update rate.
- FSM, score registers and edge detect live in `pong_game_ctrl`.

## Test plan
- Reset, then `start` pulse with TICK_DIV=4, SERVE_DELAY=2 → `ball_serve` one cycle about 8 cycles later, `serve_dir`=1, `ball_step` every 4 cycles in PLAY.
- In PLAY drive ball_x_pos=3 → right_score 0→1, `serve_dir`=0, one POINT cycle, SERVE_WAIT, serve after the delay.
- Drive ball_x_pos=640 → left_score+1, `serve_dir`=1; drive ball_x_pos=4 and 635 in different games → both edges inclusive.
- WIN_SCORE=3, three left misses → right_score=3, `game_over`=1, `winner`=1, no further `ball_step`/`ball_serve`; `start` → scores 0, new serve.
- Hold `pause` 20 cycles in PLAY → no `ball_step`, tick phase resumes unchanged; `start` edge in PLAY ignored.
- Assert reset_n low mid-SERVE_WAIT → all outputs at reset values asynchronously, IDLE after release.
